clk_sel_ctrl: RTL
=================

# clk_sel_ctrl

Clock-select controller that drives the `S` input of a BUFGMUX fed by two PLL outputs. It runs on the free-running input-reference clock, not on the muxed clock. It sequences PLL reset and lock, debounces a user switch, and commits a new select only while the PLL is settled-locked. After each switch it holds off further commits so the downstream mux domain sees clean, spaced transitions.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable synchronized cycles required before a switch change is accepted (≥1).
- `PLL_RST_CYCLES`, default 16: width of the PLL reset pulse (≥1).
- `LOCK_SETTLE_CYCLES`, default 1024: continuous lock cycles required before RUN (≥1).
- `LOCK_TIMEOUT_CYCLES`, default 100000: maximum WAIT_LOCK dwell before the PLL is reset again (≥1).
- `SWITCH_HOLDOFF`, default 64: cycles after a select commit before another commit is allowed (≥1).
- `clk` in 1: free-running reference clock; all logic is in this domain.
- `rst_n` in 1: synchronous, active-low reset.
- `sw_i` in 1: asynchronous user switch.
- `locked_i` in 1: asynchronous PLL LOCKED.
- `sel_o` out 1: registered BUFGMUX select.
- `pll_rst_o` out 1: registered PLL RST.
- `ready_o` out 1: high only in RUN.
- `switch_done_o` out 1: one-cycle pulse at the end of HOLDOFF.
- `relock_cnt_o` out 8: saturating count of lock losses and timeouts.

## Operation
- `sw_i` and `locked_i` each pass through a 2-flop synchronizer.
- The synchronized switch feeds a debouncer. `sw_db` takes the synchronized value after `DEBOUNCE_CYCLES` consecutive equal samples. Any toggle restarts the count.
- FSM states are RESET_PLL, WAIT_LOCK, SETTLE, RUN and HOLDOFF.
- **RESET_PLL**: `pll_rst_o`=1 for `PLL_RST_CYCLES` cycles, then go to WAIT_LOCK.
- **WAIT_LOCK**: `pll_rst_o`=0.
  - `lock_s`=1: go to SETTLE.
  - `LOCK_TIMEOUT_CYCLES` elapse without lock: go to RESET_PLL and increment `relock_cnt_o`.
- **SETTLE**: count continuous `lock_s`=1 cycles. After `LOCK_SETTLE_CYCLES`, go to RUN.
- **RUN**: `ready_o`=1. If `sw_db`≠`sel_o`, then `sel_o`←`sw_db` on the next edge and go to HOLDOFF.
- **HOLDOFF**: wait `SWITCH_HOLDOFF` cycles. `switch_done_o` pulses on the final cycle, then go to RUN.
  - `ready_o`=0 during HOLDOFF.
  - The debouncer keeps running. A pending mismatch is committed on the first RUN cycle.
- **Lock loss**: `lock_s`=0 in SETTLE, RUN or HOLDOFF goes to RESET_PLL and increments `relock_cnt_o`.
  - `sel_o` is frozen through relock.
  - No `switch_done_o` pulse is emitted for an aborted HOLDOFF.
- `relock_cnt_o` saturates at 255. It is cleared only by reset.
- Reset values: `sel_o`=0, `pll_rst_o`=1, `ready_o`=0, `switch_done_o`=0, `relock_cnt_o`=0, `sw_db`=0, state=RESET_PLL, all counters 0.
- Reset asserted mid-operation returns every output to its reset value on the next edge. Any pending switch is discarded.
- Counter widths are `$clog2(max+1)`. No counter wraps; each counter clears on state entry.

## Timing
- Synchronizer latency is 2 cycles.
- A `sw_i` edge held stable updates `sw_db` 2+`DEBOUNCE_CYCLES` cycles later. `sel_o` follows one cycle after that when in RUN.
- After `rst_n` rises, `pll_rst_o` is high for exactly `PLL_RST_CYCLES` cycles (reset cycles excluded).
- `ready_o` rises `LOCK_SETTLE_CYCLES`+1 cycles after SETTLE entry.
- A lock drop reaches the FSM 2 cycles after `locked_i` falls. `ready_o` falls and `pll_rst_o` rises on the following edge.
- Simultaneous lock loss and a commit request in RUN: lock loss wins and `sel_o` is unchanged.
- All outputs are registered, with no combinational path from input to output.

## Structure
- Package `clk_sel_pkg` holds:
  - the state enum `clk_sel_state_t`;
  - the relock counter width constant (8);
  - a `cnt_w(max)` width function.
- Sub-module `sync_debounce`: 2-flop synchronizer plus debounce counter, with parameter `CYCLES`.
  - Instantiated for `sw_i` with `DEBOUNCE_CYCLES`.
  - Instantiated for `locked_i` with `CYCLES`=1, i.e. synchronizer only.

## Test plan
All scenarios use params DEBOUNCE=8, PLL_RST=3, SETTLE=16, TIMEOUT=50, HOLDOFF=4.
- Release `rst_n` with `locked_i`=1 → `pll_rst_o` high 3 cycles, then `ready_o`=1 after 16 lock cycles; `sel_o`=0.
- In RUN, set `sw_i`=1 and hold → `sel_o`=1 exactly 11 cycles later, `ready_o` low 4 cycles, a single `switch_done_o` pulse, then `ready_o`=1.
- In RUN, toggle `sw_i` with period 6 cycles (bounce) → `sel_o` never changes; a final stable hold commits after 8 stable cycles.
- Drop `locked_i` during HOLDOFF → no `switch_done_o`, `pll_rst_o` 3-cycle pulse, `relock_cnt_o`=1, `sel_o` retained.
- Keep `locked_i`=0 → RESET_PLL/WAIT_LOCK loop every 53 cycles; `relock_cnt_o` increments per timeout and saturates at 255.
- Assert `rst_n`=0 mid-SETTLE → all outputs return to their reset values on the next edge.

Source files
------------

// File: rtl/clk_sel_pkg.sv
// rtl/clk_sel_pkg.sv - shared types, widths and helpers for the clock-select controller
package clk_sel_pkg;

    // Controller phases: PLL reset, lock wait, lock settle, normal run, post-switch holdoff
    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_SETTLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_HOLDOFF   = 3'd4
    } clk_sel_state_t;

    // Width of the saturating relock counter
    localparam int RELOCK_W = 8;

    // Bits needed to hold any value in 0..max
    function automatic int cnt_w(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_debounce.sv
// rtl/sync_debounce.sv - two-flop synchronizer with optional debounce filter
module sync_debounce
    import clk_sel_pkg::*;
#(
    parameter int CYCLES = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-flop synchronizer for an asynchronous input
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    generate
        if (CYCLES <= 1) begin : g_sync_only
            // A single-cycle filter adds nothing, so expose the synchronizer directly
            assign q_o = sync_q;
        end else begin : g_debounce
            localparam int CW = cnt_w(CYCLES);
            localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

            logic [CW-1:0] cnt_q;
            logic          db_q;

            // Accept a new level only after CYCLES consecutive differing samples
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                    db_q  <= 1'b0;
                end else if (sync_q == db_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == LAST) begin
                    cnt_q <= '0;
                    db_q  <= sync_q;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end

            assign q_o = db_q;
        end
    endgenerate

endmodule

// File: rtl/clk_sel_ctrl.sv
// rtl/clk_sel_ctrl.sv - PLL sequencing and glitch-safe BUFGMUX select controller
module clk_sel_ctrl
    import clk_sel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES     = 1000000,
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_SETTLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 100000,
    parameter int SWITCH_HOLDOFF      = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sw_i,
    input  logic                locked_i,
    output logic                sel_o,
    output logic                pll_rst_o,
    output logic                ready_o,
    output logic                switch_done_o,
    output logic [RELOCK_W-1:0] relock_cnt_o
);

    // One phase counter shared by all states, sized for the longest dwell
    localparam int CNT_MAX = max2(max2(PLL_RST_CYCLES, LOCK_SETTLE_CYCLES),
                                  max2(LOCK_TIMEOUT_CYCLES, SWITCH_HOLDOFF));
    localparam int CW = cnt_w(CNT_MAX);

    localparam logic [CW-1:0] RST_LAST    = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] TMO_LAST    = CW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(LOCK_SETTLE_CYCLES);
    localparam logic [CW-1:0] HOLD_LAST   = CW'(SWITCH_HOLDOFF - 1);
    localparam logic          HOLD_ONE    = (SWITCH_HOLDOFF == 1);

    logic sw_db;
    logic lock_s;

    clk_sel_state_t      state_q;
    logic [CW-1:0]       cnt_q;
    logic                sel_q;
    logic                pll_rst_q;
    logic                ready_q;
    logic                done_q;
    logic [RELOCK_W-1:0] relock_q;
    logic [RELOCK_W-1:0] relock_d;

    sync_debounce #(
        .CYCLES(DEBOUNCE_CYCLES)
    ) u_sw_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d_i  (sw_i),
        .q_o  (sw_db)
    );

    sync_debounce #(
        .CYCLES(1)
    ) u_lock_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d_i  (locked_i),
        .q_o  (lock_s)
    );

    // Saturating increment applied on every lock loss or lock timeout
    always_comb begin
        relock_d = relock_q;
        if (relock_q != {RELOCK_W{1'b1}}) begin
            relock_d = relock_q + 1'b1;
        end
    end

    // Controller FSM with registered outputs; lock loss always beats a commit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_RESET_PLL;
            cnt_q     <= '0;
            sel_q     <= 1'b0;
            pll_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            relock_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_RESET_PLL: begin
                    if (cnt_q == RST_LAST) begin
                        state_q   <= ST_WAIT_LOCK;
                        cnt_q     <= '0;
                        pll_rst_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_WAIT_LOCK: begin
                    if (lock_s) begin
                        state_q <= ST_SETTLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == TMO_LAST) begin
                        state_q   <= ST_RESET_PLL;
                        cnt_q     <= '0;
                        pll_rst_q <= 1'b1;
                        relock_q  <= relock_d;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (!lock_s) begin
                        state_q   <= ST_RESET_PLL;
                        cnt_q     <= '0;
                        pll_rst_q <= 1'b1;
                        relock_q  <= relock_d;
                    end else if (cnt_q == SETTLE_LAST) begin
                        state_q <= ST_RUN;
                        cnt_q   <= '0;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (!lock_s) begin
                        state_q   <= ST_RESET_PLL;
                        cnt_q     <= '0;
                        pll_rst_q <= 1'b1;
                        ready_q   <= 1'b0;
                        relock_q  <= relock_d;
                    end else if (sw_db != sel_q) begin
                        state_q <= ST_HOLDOFF;
                        cnt_q   <= '0;
                        sel_q   <= sw_db;
                        ready_q <= 1'b0;
                        done_q  <= HOLD_ONE;
                    end
                end
                ST_HOLDOFF: begin
                    // The done pulse is raised so it coincides with the last holdoff cycle
                    if (!lock_s) begin
                        state_q   <= ST_RESET_PLL;
                        cnt_q     <= '0;
                        pll_rst_q <= 1'b1;
                        relock_q  <= relock_d;
                    end else if (cnt_q == HOLD_LAST) begin
                        state_q <= ST_RUN;
                        cnt_q   <= '0;
                        ready_q <= 1'b1;
                    end else begin
                        cnt_q  <= cnt_q + 1'b1;
                        done_q <= ((cnt_q + 1'b1) == HOLD_LAST);
                    end
                end
                default: begin
                    state_q   <= ST_RESET_PLL;
                    cnt_q     <= '0;
                    pll_rst_q <= 1'b1;
                    ready_q   <= 1'b0;
                end
            endcase
        end
    end

    assign sel_o         = sel_q;
    assign pll_rst_o     = pll_rst_q;
    assign ready_o       = ready_q;
    assign switch_done_o = done_q;
    assign relock_cnt_o  = relock_q;

endmodule
